// File: rtl/serial_minuend_restorer.sv
// Bit-serial minuend restorer: rebuilds X = D + Y + Bin one bit per clock, LSB first.
// The final carry equals the borrow-out of the subtraction that produced D.
module serial_minuend_restorer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] diff,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] minuend,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             c;
  logic [CNT_W-1:0] cnt;

  function automatic logic fa_sum(input logic a, input logic b, input logic ci);
    return a ^ b ^ ci;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic ci);
    return (a & b) | (a & ci) | (b & ci);
  endfunction

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] r_next;

  assign s_bit  = fa_sum(a_sr[0], b_sr[0], c);
  assign c_next = fa_carry(a_sr[0], b_sr[0], c);
  assign r_next = {s_bit, r_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      r_sr      <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      minuend   <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= diff;
            b_sr  <= subtrahend;
            c     <= borrow_in;
            r_sr  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= r_next;
          c    <= c_next;
          cnt  <= cnt + 1'b1;
          // Outputs update only here, so partial sums never reach minuend.
          if (cnt == CNT_LAST) begin
            minuend   <= r_next;
            carry_out <= c_next;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_minuend_restorer.sv
// Scoreboard bench for serial_minuend_restorer: expected X/carry queued at start, compared on done.
module tb_serial_minuend_restorer;

  localparam int WIDTH = 5;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] subtrahend;
  logic             borrow_in;
  logic [WIDTH-1:0] minuend;
  logic             carry_out;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_err    = 0;

  logic [WIDTH:0]   sb[$];
  logic [WIDTH-1:0] last_min = '0;

  serial_minuend_restorer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .diff       (diff),
    .subtrahend (subtrahend),
    .borrow_in  (borrow_in),
    .minuend    (minuend),
    .carry_out  (carry_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Result monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [WIDTH:0] e;
        e = sb.pop_front();
        check_val("minuend", 32'(minuend), 32'(e[WIDTH-1:0]));
        check_val("carry_out", 32'(carry_out), 32'(e[WIDTH]));
      end
    end
  end

  // Runs one operation; glitch=1 re-pulses start with other operands at edge 2.
  task automatic run_op(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] y,
                        input logic b, input bit glitch);
    logic [WIDTH:0] e;
    int cyc;
    e = {1'b0, d} + {1'b0, y} + (WIDTH+1)'(b);
    diff = d; subtrahend = y; borrow_in = b; start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check_val("busy_after_start", 32'(busy), 32'd1);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
      check_val("minuend_hold", 32'(minuend), 32'(last_min));
      if (glitch && cyc == 1) begin
        diff = ~d; subtrahend = d ^ y; borrow_in = ~b; start = 1'b1;
      end
      if (glitch && cyc == 2) start = 1'b0;
    end
    if (!done) check_val("done_timeout", 32'd0, 32'd1);
    check_val("done_latency", 32'(cyc), 32'(WIDTH));
    last_min = e[WIDTH-1:0];
    @(posedge clk); #1;
    check_val("done_one_cycle", 32'(done), 32'd0);
    check_val("busy_cleared", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; diff = '0; subtrahend = '0; borrow_in = 1'b0;
    #1;
    check_val("rst_minuend", 32'(minuend), 32'd0);
    check_val("rst_carry", 32'(carry_out), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(5'b00010, 5'b00011, 1'b0, 1'b0);
    run_op(5'b01000, 5'b00111, 1'b0, 1'b0);
    run_op(5'b11110, 5'b00011, 1'b0, 1'b0);
    run_op(5'b00001, 5'b00011, 1'b1, 1'b0);
    run_op(5'b10110, 5'b01101, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);

    // Abort an operation with an asynchronous reset between edges 3 and 4.
    diff = 5'b11111; subtrahend = 5'b00001; borrow_in = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check_val("abort_minuend", 32'(minuend), 32'd0);
    check_val("abort_carry", 32'(carry_out), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    last_min = '0;
    for (int i = 0; i < WIDTH + 3; i++) begin
      @(posedge clk); #1;
      check_val("no_done_after_abort", 32'(done), 32'd0);
    end

    run_op(5'b01010, 5'b10011, 1'b1, 1'b0);
    run_op(5'b00000, 5'b11111, 1'b1, 1'b0);

    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
